dmem_responder: RTL

- Multi-cycle data-memory responder: the target side of the MEM-stage load/store interface driven by the pipelined datapath.
- Accepts a read or write request and holds the pipeline with Stall while the access is in progress.
- Performs byte-lane stores, and sign- or zero-extended loads of bytes and halfwords.
- Signals completion with a one-cycle Ready pulse, and flags misaligned accesses.

---
 rtl/dmem_responder.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle target for MEM-stage loads/stores with byte-lane writes,
// sign/zero-extended loads, Stall hold, one-cycle Ready pulse and misalignment flag.
module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   input  logic [1:0]  Size,
   input  logic        Unsigned,
   output logic [31:0] ReadData,
   output logic        Ready,
   output logic        Stall,
   output logic        AlignErr
);
   localparam int         AW        = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WAIT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
   localparam logic       ZERO_LAT  = (LATENCY == 0);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_RESP = 2'd2} state_t;

   state_t        state_q;
   logic [3:0]    cnt_q;
   logic [AW+1:0] addr_q;
   logic [31:0]   wdata_q;
   logic [31:0]   rdata_q;
   logic [1:0]    size_q;
   logic          uns_q;
   logic          write_q;
   logic          err_q;
   logic          ready_q;
   logic          aerr_q;

   logic [31:0]   mem [DEPTH_WORDS];

   function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
      case (sz)
         2'b00:   return (a != 2'b00);
         2'b01:   return a[0];
         2'b10:   return 1'b0;
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] a,
                                            input logic [1:0] sz, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{a, 3'b000} +: 8];
      h = a[1] ? word[31:16] : word[15:0];
      case (sz)
         2'b00:   return word;
         2'b01:   return {{16{~uns & h[15]}}, h};
         2'b10:   return {{24{~uns & b[7]}}, b};
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [1:0] a, input logic [1:0] sz);
      logic [31:0] r;
      r = old;
      case (sz)
         2'b00:   r = wd;
         2'b01:   r[{a[1], 4'b0000} +: 16] = wd[15:0];
         2'b10:   r[{a, 3'b000} +: 8] = wd[7:0];
         default: r = old;
      endcase
      return r;
   endfunction

   logic          req_s;
   logic          err_in_s;
   logic [AW+1:0] cur_addr_s;
   logic [1:0]    cur_size_s;
   logic          cur_uns_s;
   logic          cur_err_s;
   logic          cur_read_s;
   logic [31:0]   rd_word_s;
   logic [31:0]   load_s;
   logic          unused_s;

   assign req_s    = MemRead | MemWrite;
   assign err_in_s = (MemRead & MemWrite) | misaligned(Size, Address[1:0]);
   assign unused_s = ^Address[31:AW+2];

   // Access fields of the current cycle: live inputs while idle (zero latency), latched copy afterwards
   always_comb begin
      if (state_q == ST_IDLE) begin
         cur_addr_s = Address[AW+1:0];
         cur_size_s = Size;
         cur_uns_s  = Unsigned;
         cur_err_s  = err_in_s;
         cur_read_s = MemRead;
      end else begin
         cur_addr_s = addr_q;
         cur_size_s = size_q;
         cur_uns_s  = uns_q;
         cur_err_s  = err_q;
         cur_read_s = ~write_q;
      end
      rd_word_s = mem[cur_addr_s[AW+1:2]];
      if (cur_err_s) begin
         load_s = 32'd0;
      end else if (cur_read_s) begin
         load_s = load_ext(rd_word_s, cur_addr_s[1:0], cur_size_s, cur_uns_s);
      end else begin
         load_s = rdata_q;
      end
   end

   assign Stall    = ((state_q == ST_IDLE) & req_s) | (state_q == ST_WAIT);
   assign Ready    = ready_q;
   assign AlignErr = aerr_q;
   assign ReadData = rdata_q;

   // Request FSM with registered response outputs
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         size_q  <= 2'd0;
         uns_q   <= 1'b0;
         write_q <= 1'b0;
         err_q   <= 1'b0;
         ready_q <= 1'b0;
         aerr_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               ready_q <= 1'b0;
               aerr_q  <= 1'b0;
               if (req_s) begin
                  addr_q  <= Address[AW+1:0];
                  wdata_q <= WriteData;
                  size_q  <= Size;
                  uns_q   <= Unsigned;
                  write_q <= MemWrite;
                  err_q   <= err_in_s;
                  if (ZERO_LAT) begin
                     state_q <= ST_RESP;
                     ready_q <= 1'b1;
                     aerr_q  <= err_in_s;
                     rdata_q <= load_s;
                  end else begin
                     state_q <= ST_WAIT;
                     cnt_q   <= WAIT_LOAD;
                  end
               end
            end
            ST_WAIT: begin
               if (cnt_q == 4'd0) begin
                  state_q <= ST_RESP;
                  ready_q <= 1'b1;
                  aerr_q  <= err_q;
                  rdata_q <= load_s;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            ST_RESP: begin
               state_q <= ST_IDLE;
               ready_q <= 1'b0;
               aerr_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               ready_q <= 1'b0;
               aerr_q  <= 1'b0;
            end
         endcase
      end
   end

   // Store commit on the edge leaving RESP; a reset in RESP drops it
   always_ff @(posedge Clk) begin
      if (!Reset && (state_q == ST_RESP) && write_q && !err_q) begin
         mem[addr_q[AW+1:2]] <= store_merge(mem[addr_q[AW+1:2]], wdata_q, addr_q[1:0], size_q);
      end
   end
endmodule
